// File: rtl/shl_seq_ctrl.sv
// Multi-cycle 32-bit left shifter: one power-of-two stage (1,2,4,8,16) per clock,
// operand and amount taken over a valid/ready handshake, result returned over another.
module shl_seq_ctrl #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic [2:0]  stage
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] acc;
  logic [4:0]  rem;
  logic [2:0]  k;

  logic        rem_bit;
  logic [31:0] acc_stage;
  logic [4:0]  rem_next;
  logic        last_stage;

  // Stage k shifts by 2^k; only one stage shifter is active per cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rem_bit   = 1'b0;
    acc_stage = acc;
    case (k)
      3'd0: begin rem_bit = rem[0]; acc_stage = {acc[30:0], 1'b0};  end
      3'd1: begin rem_bit = rem[1]; acc_stage = {acc[29:0], 2'b0};  end
      3'd2: begin rem_bit = rem[2]; acc_stage = {acc[27:0], 4'b0};  end
      3'd3: begin rem_bit = rem[3]; acc_stage = {acc[23:0], 8'b0};  end
      3'd4: begin rem_bit = rem[4]; acc_stage = {acc[15:0], 16'b0}; end
      default: begin rem_bit = 1'b0; acc_stage = acc; end
    endcase
    rem_next   = rem & ~(5'd1 << k);
    last_stage = (k == 3'd4) || (EARLY_EXIT && (rem_next == 5'd0));
  end

  // An amount of 0 still passes through stage 0, where the early exit fires at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= in_data;
            rem   <= in_amt;
            k     <= 3'd0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= rem_bit ? acc_stage : acc;
          rem <= rem_next;
          k   <= k + 3'd1;
          if (last_stage) state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            k     <= 3'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; nothing combinational from in_* or out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign stage     = (state == SHIFT) ? k : 3'd0;
  assign out_data  = acc;

endmodule

// File: tb/tb_shl_seq_ctrl.sv
// Directed bench for shl_seq_ctrl: one instance per EARLY_EXIT value, hand-computed
// results and latencies, backpressure, mid-operation reset, and a short random sweep.
module tb_shl_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic [4:0]  in_amt    [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic        busy      [2];
  logic [2:0]  stage     [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shl_seq_ctrl #(.EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_amt(in_amt[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]), .stage(stage[0])
  );

  shl_seq_ctrl #(.EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_amt(in_amt[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]), .stage(stage[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input bit ee, input logic [4:0] a);
    if (!ee) return 5;
    for (int i = 4; i >= 0; i--) if (a[i]) return i + 1;
    return 1;
  endfunction

  task automatic check_reset_outputs(input int idx);
    check("rst_in_ready",  in_ready[idx],  32'd1);
    check("rst_out_valid", out_valid[idx], 32'd0);
    check("rst_out_data",  out_data[idx],  32'd0);
    check("rst_busy",      busy[idx],      32'd0);
    check("rst_stage",     stage[idx],     32'd0);
  endtask

  // One request: accept, measure edges to out_valid, hold off out_ready for
  // 'hold' cycles, then complete the output handshake and confirm IDLE.
  task automatic do_req(input int idx, input logic [31:0] d, input logic [4:0] a,
                        input logic [31:0] exp, input int exp_l, input int hold,
                        input bit noise, output logic [14:0] trace);
    int lat;
    trace = '0;
    lat   = 0;
    @(negedge clk);
    check("ready_before_accept", in_ready[idx], 32'd1);
    in_valid[idx]  = 1'b1;
    in_data[idx]   = d;
    in_amt[idx]    = a;
    out_ready[idx] = (hold == 0);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    check("in_ready_low_after_accept", in_ready[idx], 32'd0);
    while (!out_valid[idx] && lat < 40) begin
      if (lat <= 4) trace[3*lat +: 3] = stage[idx];
      if (noise) begin
        in_valid[idx] = 1'($urandom_range(0, 1));
        in_data[idx]  = $urandom;
        in_amt[idx]   = 5'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid[idx] = 1'b0;
    check("result_valid", out_valid[idx], 32'd1);
    check("result_data", out_data[idx], exp);
    check("latency", lat, exp_l);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid[idx] = ~in_valid[idx];
        in_data[idx]  = ~in_data[idx];
      end
      @(negedge clk);
      check("hold_valid", out_valid[idx], 32'd1);
      check("hold_data", out_data[idx], exp);
      check("hold_busy", busy[idx], 32'd1);
      check("hold_no_accept", in_ready[idx], 32'd0);
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    @(negedge clk);
    check("post_hs_in_ready", in_ready[idx], 32'd1);
    check("post_hs_out_valid", out_valid[idx], 32'd0);
    out_ready[idx] = 1'b0;
  endtask

  initial begin
    logic [14:0] trace;
    logic [31:0] d;
    logic [4:0]  a;
    int          guard;

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; in_amt[i] = '0; out_ready[i] = 1'b0;
    end

    // Reset values while held in reset.
    #12;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-length sequence, highest amount.
    do_req(0, 32'h0000_0001, 5'd31, 32'h8000_0000, 5, 0, 1'b0, trace);

    // Amount 0: full latency without early exit, one edge with it.
    do_req(0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 5, 0, 1'b0, trace);
    do_req(1, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 0, 1'b0, trace);

    // Early exit: amount 20 walks every stage, amount 3 stops after stage 1.
    do_req(1, 32'hFFFF_FFFF, 5'd20, 32'hFFF0_0000, 5, 0, 1'b0, trace);
    check("stage_sequence_amt20", 32'(trace), 32'(15'o43210));
    do_req(1, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFF8, 2, 0, 1'b0, trace);
    do_req(1, 32'h0000_0001, 5'd1, 32'h0000_0002, 1, 0, 1'b0, trace);
    do_req(0, 32'h8000_0001, 5'd1, 32'h0000_0002, 5, 0, 1'b0, trace);

    // Backpressure: 10 cycles of out_ready low with in_valid/in_data toggling.
    do_req(0, 32'hA5A5_0F0F, 5'd8, 32'hA50F_0F00, 5, 10, 1'b1, trace);

    // Abort by reset during stage 2.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 32'hCAFE_BABE; in_amt[0] = 5'd31; out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    guard = 0;
    while (stage[0] != 3'd2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_stage2", stage[0], 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_valid_in_reset", out_valid[0], 32'd0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_spurious_valid", out_valid[0], 32'd0);
    end
    out_ready[0] = 1'b0;
    do_req(0, 32'h1234_5678, 5'd4, 32'h2345_6780, 5, 0, 1'b0, trace);

    // Random sweep on both instances against the shift model.
    for (int idx = 0; idx < 2; idx++) begin
      for (int n = 0; n < 300; n++) begin
        d = $urandom;
        a = 5'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_req(idx, d, a, d << a, exp_lat(idx == 1, a), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), trace);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
